bs_job_scheduler: RTL and testbench
===================================

// Module: bs_job_scheduler
// PURPOSE
//  Multi-requester front end for the Black-Scholes pricing core (d1d2 -> 2x norm -> OptionPrice).
//  The core has no handshake and its start input is tied high. This block does four things:
//  - arbitrates NREQ requesters round-robin;
//  - latches one job's Q16.16 operands and holds them stable on the core inputs for CORE_LAT cycles;
//  - captures the core's OptionPrice;
//  - returns the result, tagged with the requester ID, over a valid/ready port.
//  One job is in flight at a time. Invalid operands are rejected without using the core.
// PARAMETERS
//  WIDTH     32  operand/result width, Q16.16 signed
//  NREQ      4   number of requesters, >=2
//  IDW       2   requester ID width, = clog2(NREQ)
//  CORE_LAT  8   cycles from stable core inputs to valid core OptionPrice, >=1
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-high reset
//  req        in   NREQ        per-requester job request, level
//  req_spot   in   NREQ*WIDTH  flattened spot; slice i = [i*WIDTH +: WIDTH]
//  req_strike in   NREQ*WIDTH  flattened strike
//  req_timetm in   NREQ*WIDTH  flattened time to maturity
//  req_sigma  in   NREQ*WIDTH  flattened volatility
//  req_rate   in   NREQ*WIDTH  flattened risk-free rate
//  req_otype  in   NREQ        0 = call, 1 = put
//  gnt        out  NREQ        one-hot, one-cycle pulse: requester's job accepted
//  core_spot/core_strike/core_timetm/core_sigma/core_rate  out  WIDTH each  registered core operands
//  core_otype out  1           registered option type to core
//  core_price in   WIDTH       OptionPrice from core
//  res_valid  out  1           result valid
//  res_ready  in   1           consumer accepts result
//  res_data   out  WIDTH       option price, Q16.16
//  res_id     out  IDW         requester index of result
//  res_err    out  1           1 = operands rejected, res_data = 0
//  busy       out  1           high in any state except IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; rr pointer 0; state IDLE. Reset mid-job drops the job with no response.
//  States: IDLE, RUN, RESP.
//  - IDLE, any req: pick the first asserted req at or after ptr (mod NREQ); pulse gnt[i]; set ptr <= i+1 mod NREQ.
//    Operand check: spot, strike, timetm and sigma must all be >0; rate may be any value.
//    - Valid: latch slice i into core_*, cnt <= CORE_LAT-1, go RUN.
//    - Invalid: core_* unchanged, res_err=1, res_data=0, res_id=i, res_valid=1, go RESP.
//  - RUN: core_* held constant; cnt decrements each cycle. When cnt==0, next edge:
//    res_data <= core_price, res_err=0, res_id=latched i, res_valid=1, go RESP.
//    Operands are applied at edge E and the price is sampled at edge E+CORE_LAT.
//  - RESP: res_* held stable until res_valid && res_ready; that edge clears res_valid and goes IDLE.
//    A grant can issue on the following cycle at the earliest.
//  Requester rules:
//  - Hold req and the operand slice until gnt.
//  - Dropping req before gnt is legal and leaves no state behind.
//  - req[i] still high on the cycle after gnt[i] counts as a new job.
//  Throughput: valid job CORE_LAT+2 cycles min; rejected job 2 cycles min.
//  gnt is only asserted in IDLE; at most one bit set. No req in IDLE: nothing changes.
//  Sign checks use the MSB of each WIDTH slice; a zero value counts as invalid.
//  Ptr wraps NREQ-1 -> 0. Simultaneous requests: strict rotation, no starvation.
//    A given requester waits at most NREQ-1 jobs.
// STRUCTURE
//  bs_pkg: WIDTH default, Q16.16 ONE constant (32'h00010000), state encoding localparams, operand field order.
//  Sub-module rr_arbiter (req, ptr -> one-hot gnt, index). The FSM, counter and registers live in this block.
// TESTING
//  Bench uses a core model: price = f(operands) after exactly CORE_LAT cycles, X before that.
//  1 Single call, req[0]: spot=0x00640000, strike=0x00640000, T=0x00010000, sigma=0x00003333, rate=0x00000CCD.
//    -> gnt[0] one cycle; core_* stable for 8 cycles.
//    -> res_valid on cycle 10 after req; res_data = model value (~10.45 = 0x000A7333 +/- LSBs); res_id=0, res_err=0.
//  2 req=4'b1111 held for 4 jobs, ptr=0 -> grant order 0,1,2,3; then 0 again; res_id matches each.
//  3 req[2] with sigma=0 -> res_err=1, res_data=0, res_id=2 within 2 cycles; core_* unchanged; no RUN state.
//  4 res_ready low for 5 cycles in RESP -> res_* stable, no gnt despite pending req; grant on cycle after handshake.
//  5 reset asserted mid-RUN (cnt=3) -> all outputs 0 immediately (asynchronous); busy=0; after release, a new job completes normally.
//  6 req[1] pulsed 1 cycle while busy, then dropped -> never granted, no response produced.

Source files
------------

// File: rtl/bs_job_scheduler_pkg.sv
// rtl/bs_job_scheduler_pkg.sv - shared types and constants for the Black-Scholes job scheduler
package bs_job_scheduler_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int NREQ_DEF     = 4;
    localparam int IDW_DEF      = 2;
    localparam int CORE_LAT_DEF = 8;

    // Q16.16 representation of 1.0
    localparam logic [31:0] Q16_ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Operand order as presented to the pricing core
    localparam int FLD_SPOT   = 0;
    localparam int FLD_STRIKE = 1;
    localparam int FLD_TIMETM = 2;
    localparam int FLD_SIGMA  = 3;
    localparam int FLD_RATE   = 4;
    localparam int NUM_FIELDS = 5;

endpackage

// File: rtl/bs_job_scheduler_if.sv
// rtl/bs_job_scheduler_if.sv - requester and result port bundle of the job scheduler
interface bs_job_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_spot;
    logic [NREQ*WIDTH-1:0] req_strike;
    logic [NREQ*WIDTH-1:0] req_timetm;
    logic [NREQ*WIDTH-1:0] req_sigma;
    logic [NREQ*WIDTH-1:0] req_rate;
    logic [NREQ-1:0]       req_otype;
    logic [NREQ-1:0]       gnt;

    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic [IDW-1:0]        res_id;
    logic                  res_err;

    modport master (
        output req, req_spot, req_strike, req_timetm, req_sigma, req_rate, req_otype,
        input  gnt,
        input  res_valid, res_data, res_id, res_err,
        output res_ready
    );

    modport slave (
        input  req, req_spot, req_strike, req_timetm, req_sigma, req_rate, req_otype,
        output gnt,
        output res_valid, res_data, res_id, res_err,
        input  res_ready
    );

endinterface

// File: rtl/bs_job_scheduler_rr_arbiter.sv
// rtl/bs_job_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module bs_job_scheduler_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[rot(ptr, k)]) begin
                any             = 1'b1;
                idx             = rot(ptr, k);
                gnt[rot(ptr, k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bs_job_scheduler.sv
// rtl/bs_job_scheduler.sv - round-robin front end holding one job on the pricing core at a time
module bs_job_scheduler
    import bs_job_scheduler_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NREQ     = NREQ_DEF,
    parameter int IDW      = IDW_DEF,
    parameter int CORE_LAT = CORE_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    bs_job_scheduler_if.slave job,
    output logic [WIDTH-1:0] core_spot,
    output logic [WIDTH-1:0] core_strike,
    output logic [WIDTH-1:0] core_timetm,
    output logic [WIDTH-1:0] core_sigma,
    output logic [WIDTH-1:0] core_rate,
    output logic             core_otype,
    input  logic [WIDTH-1:0] core_price,
    output logic             busy
);

    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] spot_q, spot_d;
    logic [WIDTH-1:0] strike_q, strike_d;
    logic [WIDTH-1:0] timetm_q, timetm_d;
    logic [WIDTH-1:0] sigma_q, sigma_d;
    logic [WIDTH-1:0] rate_q, rate_d;
    logic             otype_q, otype_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             res_err_q, res_err_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;

    logic [WIDTH-1:0] sel_spot, sel_strike, sel_timetm, sel_sigma, sel_rate;
    logic             sel_otype;
    logic             ops_ok;

    bs_job_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (job.req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Strictly positive: sign bit clear and not zero
    function automatic logic is_pos(input logic [WIDTH-1:0] v);
        return !v[WIDTH-1] && (|v);
    endfunction

    always_comb begin
        sel_spot   = job.req_spot  [int'(arb_idx)*WIDTH +: WIDTH];
        sel_strike = job.req_strike[int'(arb_idx)*WIDTH +: WIDTH];
        sel_timetm = job.req_timetm[int'(arb_idx)*WIDTH +: WIDTH];
        sel_sigma  = job.req_sigma [int'(arb_idx)*WIDTH +: WIDTH];
        sel_rate   = job.req_rate  [int'(arb_idx)*WIDTH +: WIDTH];
        sel_otype  = job.req_otype [arb_idx];
        ops_ok     = is_pos(sel_spot) && is_pos(sel_strike) &&
                     is_pos(sel_timetm) && is_pos(sel_sigma);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        spot_d      = spot_q;
        strike_d    = strike_q;
        timetm_d    = timetm_q;
        sigma_d     = sigma_q;
        rate_d      = rate_q;
        otype_d     = otype_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_d = arb_gnt;
                    ptr_d = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
                    id_d  = arb_idx;
                    if (ops_ok) begin
                        spot_d   = sel_spot;
                        strike_d = sel_strike;
                        timetm_d = sel_timetm;
                        sigma_d  = sel_sigma;
                        rate_d   = sel_rate;
                        otype_d  = sel_otype;
                        cnt_d    = CW'(CORE_LAT-1);
                        state_d  = ST_RUN;
                    end else begin
                        // Rejected jobs bypass the core, leaving its operands untouched
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_data_d  = '0;
                        res_id_d    = arb_idx;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                    res_data_d  = core_price;
                    res_id_d    = id_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (job.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            spot_q      <= '0;
            strike_q    <= '0;
            timetm_q    <= '0;
            sigma_q     <= '0;
            rate_q      <= '0;
            otype_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            spot_q      <= spot_d;
            strike_q    <= strike_d;
            timetm_q    <= timetm_d;
            sigma_q     <= sigma_d;
            rate_q      <= rate_d;
            otype_q     <= otype_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
        end
    end

    assign job.gnt       = gnt_q;
    assign job.res_valid = res_valid_q;
    assign job.res_data  = res_data_q;
    assign job.res_id    = res_id_q;
    assign job.res_err   = res_err_q;
    assign core_spot     = spot_q;
    assign core_strike   = strike_q;
    assign core_timetm   = timetm_q;
    assign core_sigma    = sigma_q;
    assign core_rate     = rate_q;
    assign core_otype    = otype_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bs_job_scheduler.sv
// tb/tb_bs_job_scheduler.sv - self-checking bench for bs_job_scheduler with a fixed-latency core model
module tb_bs_job_scheduler;
    import bs_job_scheduler_pkg::*;

    localparam int WIDTH    = 32;
    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int CORE_LAT = 8;
    // Stands in for X: what the core drives before its inputs have settled long enough
    localparam logic [WIDTH-1:0] POISON = 32'hBAD0_BAD0;

    typedef struct packed {
        logic [31:0] spot;
        logic [31:0] strike;
        logic [31:0] timetm;
        logic [31:0] sigma;
        logic [31:0] rate;
        logic        otype;
    } op_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic           err;
        logic [31:0]    data;
    } exp_t;

    typedef struct {
        int   idx;
        op_t  ops;
        logic exp_err;
        int   exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bs_job_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) job ();

    logic [WIDTH-1:0] core_spot, core_strike, core_timetm, core_sigma, core_rate, core_price;
    logic             core_otype;
    logic             busy;

    bs_job_scheduler #(
        .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CORE_LAT(CORE_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .job         (job),
        .core_spot   (core_spot),
        .core_strike (core_strike),
        .core_timetm (core_timetm),
        .core_sigma  (core_sigma),
        .core_rate   (core_rate),
        .core_otype  (core_otype),
        .core_price  (core_price),
        .busy        (busy)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    int   gnt_log[$];
    int   gnt1_seen = 0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] s, input logic [31:0] k, input logic [31:0] t,
                                  input logic [31:0] v, input logic [31:0] r, input logic ot);
        op_t o;
        o.spot = s; o.strike = k; o.timetm = t; o.sigma = v; o.rate = r; o.otype = ot;
        return o;
    endfunction

    function automatic logic pos(input logic [31:0] v);
        return !v[31] && (v != 32'h0);
    endfunction

    function automatic logic ops_ok(input op_t o);
        return pos(o.spot) && pos(o.strike) && pos(o.timetm) && pos(o.sigma);
    endfunction

    // Reference vector returns the textbook price; anything else a deterministic mix
    function automatic logic [31:0] core_fn(input op_t o);
        if (o.spot == 32'h00640000 && o.strike == 32'h00640000 && o.timetm == 32'h00010000 &&
            o.sigma == 32'h00003333 && o.rate == 32'h00000CCD && !o.otype)
            return 32'h000A7333;
        return (o.spot - o.strike) ^ {o.timetm[15:0], o.sigma[15:0]} ^ (o.rate + {31'b0, o.otype});
    endfunction

    // Core model: valid only once the inputs have been stable for CORE_LAT cycles
    op_t core_now;
    op_t core_prev = '0;
    int  age = 0;
    always_comb core_now = {core_spot, core_strike, core_timetm, core_sigma, core_rate, core_otype};
    always @(posedge clk) begin
        if (core_now == core_prev) age <= age + 1;
        else                       age <= 1;
        core_prev <= core_now;
    end
    assign core_price = (core_now == core_prev && age >= CORE_LAT-1) ? core_fn(core_now) : POISON;

    task automatic set_ops(input int i, input op_t o);
        job.req_spot  [i*WIDTH +: WIDTH] = o.spot;
        job.req_strike[i*WIDTH +: WIDTH] = o.strike;
        job.req_timetm[i*WIDTH +: WIDTH] = o.timetm;
        job.req_sigma [i*WIDTH +: WIDTH] = o.sigma;
        job.req_rate  [i*WIDTH +: WIDTH] = o.rate;
        job.req_otype [i]                = o.otype;
    endtask

    function automatic op_t get_ops(input int i);
        return mk_op(job.req_spot[i*WIDTH +: WIDTH], job.req_strike[i*WIDTH +: WIDTH],
                     job.req_timetm[i*WIDTH +: WIDTH], job.req_sigma[i*WIDTH +: WIDTH],
                     job.req_rate[i*WIDTH +: WIDTH], job.req_otype[i]);
    endfunction

    // Scoreboard: expectation pushed at grant, popped at the result handshake
    int   mon_gi;
    op_t  mon_o;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (job.gnt != '0) begin
                check("gnt_onehot", $onehot(job.gnt), 1);
                mon_gi = 0;
                for (int k = 0; k < NREQ; k++) if (job.gnt[k]) mon_gi = k;
                if (mon_gi == 1) gnt1_seen++;
                mon_o = get_ops(mon_gi);
                mon_e.id   = IDW'(mon_gi);
                mon_e.err  = !ops_ok(mon_o);
                mon_e.data = ops_ok(mon_o) ? core_fn(mon_o) : 32'h0;
                sb_q.push_back(mon_e);
                gnt_log.push_back(mon_gi);
            end
            if (job.res_valid && job.res_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_response", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_res_id",   job.res_id,   mon_e.id);
                    check("sb_res_err",  job.res_err,  mon_e.err);
                    check("sb_res_data", job.res_data, mon_e.data);
                end
            end
        end
    end

    task automatic wait_gnt(input int i, output bit got);
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk); #1;
            if (job.gnt[i]) got = 1'b1;
        end
    endtask

    task automatic wait_resp(output int lat);
        bit seen;
        lat  = 0;
        seen = job.res_valid;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge clk); #1;
            lat++;
            seen = job.res_valid;
        end
        check("resp_seen", seen, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk); #1;
            if (!busy && !job.res_valid) done = 1'b1;
        end
        check("idle_reached", done, 1);
    endtask

    task automatic run_job(input int i, input op_t o, output int lat);
        bit got;
        set_ops(i, o);
        job.req[i] = 1'b1;
        wait_gnt(i, got);
        job.req[i] = 1'b0;
        check("gnt_seen", got, 1);
        wait_resp(lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[7];
    int   lat, ngnt;
    bit   got;
    op_t  o1, snap;
    logic [WIDTH+IDW+1:0] res_snap;
    int   exp_order[5];

    initial begin
        vecs[0] = '{3, mk_op(32'h00500000, 32'h00480000, 32'h00008000, 32'h00004000, 32'hFFFF8000, 1'b1), 1'b0, CORE_LAT};
        vecs[1] = '{1, mk_op(32'h00000000, 32'h00480000, 32'h00008000, 32'h00004000, 32'h00000100, 1'b0), 1'b1, 0};
        vecs[2] = '{2, mk_op(32'h00500000, 32'h80000000, 32'h00008000, 32'h00004000, 32'h00000100, 1'b0), 1'b1, 0};
        vecs[3] = '{0, mk_op(32'h00500000, 32'h00480000, 32'hFFFFFFFF, 32'h00004000, 32'h00000100, 1'b1), 1'b1, 0};
        vecs[4] = '{1, mk_op(32'h7FFFFFFF, 32'h00010000, 32'h00020000, 32'h00000001, 32'h00000000, 1'b0), 1'b0, CORE_LAT};
        vecs[5] = '{2, mk_op(32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h80000000, 1'b1), 1'b0, CORE_LAT};
        vecs[6] = '{3, mk_op(32'h00300000, 32'h00280000, 32'h00010000, 32'h00000000, 32'h00000200, 1'b0), 1'b1, 0};
        exp_order = '{0, 1, 2, 3, 0};

        reset          = 1'b1;
        job.req        = '0;
        job.req_spot   = '0;
        job.req_strike = '0;
        job.req_timetm = '0;
        job.req_sigma  = '0;
        job.req_rate   = '0;
        job.req_otype  = '0;
        job.res_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {job.gnt, job.res_valid, job.res_err, job.res_data, job.res_id, busy,
                              core_spot, core_otype}, 0);
        reset = 1'b0;

        // Simultaneous requests rotate from ptr=0
        gnt_log.delete();
        for (int i = 0; i < NREQ; i++)
            set_ops(i, mk_op(32'h00100000*(i+1), 32'h00080000*(i+2), 32'h00004000+i, 32'h00002000+i, 32'h00000040*i, i[0]));
        job.req = '1;
        ngnt = 0;
        for (int c = 0; c < 200 && ngnt < 5; c++) begin
            @(posedge clk); #1;
            if (job.gnt != '0) begin
                ngnt++;
                if (ngnt == 5) job.req = '0;
            end
        end
        job.req = '0;
        check("rr_grant_count", ngnt, 5);
        wait_idle();
        check("rr_log_size", gnt_log.size(), 5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++)
            check("rr_order", gnt_log[k], exp_order[k]);

        // Reference call on requester 0: operands held for CORE_LAT cycles, result after that
        o1 = mk_op(32'h00640000, 32'h00640000, 32'h00010000, 32'h00003333, 32'h00000CCD, 1'b0);
        set_ops(0, o1);
        job.req[0] = 1'b1;
        wait_gnt(0, got);
        job.req[0] = 1'b0;
        check("t1_gnt_seen", got, 1);
        check("t1_gnt", job.gnt, 4'b0001);
        check("t1_core_hold", core_now, o1);
        for (int c = 1; c <= CORE_LAT; c++) begin
            @(posedge clk); #1;
            if (c < CORE_LAT) check("t1_core_hold", core_now, o1);
            check("t1_res_valid", job.res_valid, (c == CORE_LAT));
            check("t1_gnt_pulse", job.gnt, 0);
        end
        check("t1_res_data", job.res_data, 32'h000A7333);
        check("t1_res_id",   job.res_id,   0);
        check("t1_res_err",  job.res_err,  0);
        wait_idle();

        // Table-driven single jobs, including operand boundary cases
        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].idx, vecs[v].ops, lat);
            check("vec_latency", lat, vecs[v].exp_lat);
            check("vec_res_err", job.res_err, vecs[v].exp_err);
            check("vec_res_id",  job.res_id,  vecs[v].idx);
            wait_idle();
        end

        // Rejected job on requester 2 leaves the core untouched and turns around in 2 cycles
        snap = core_now;
        set_ops(2, mk_op(32'h00200000, 32'h00200000, 32'h00010000, 32'h00000000, 32'h00000100, 1'b0));
        job.req[2] = 1'b1;
        wait_gnt(2, got);
        job.req[2] = 1'b0;
        check("t3_gnt_seen", got, 1);
        check("t3_res", {job.res_valid, job.res_err, job.res_data, job.res_id}, {1'b1, 1'b1, 32'h0, 2'd2});
        check("t3_core_unchanged", core_now, snap);
        @(posedge clk); #1;
        check("t3_back_idle", {busy, job.res_valid}, 0);
        check("t3_core_unchanged", core_now, snap);

        // Back-pressure: result stays put and no grant until the handshake
        job.res_ready = 1'b0;
        set_ops(0, mk_op(32'h00110000, 32'h00120000, 32'h00013000, 32'h00001400, 32'h00000015, 1'b1));
        job.req[0] = 1'b1;
        wait_gnt(0, got);
        job.req[0] = 1'b0;
        check("t4_gnt_seen", got, 1);
        set_ops(1, mk_op(32'h00210000, 32'h00220000, 32'h00023000, 32'h00002400, 32'h00000025, 1'b0));
        job.req[1] = 1'b1;
        wait_resp(lat);
        res_snap = {job.res_valid, job.res_err, job.res_data, job.res_id};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("t4_res_stable", {job.res_valid, job.res_err, job.res_data, job.res_id}, res_snap);
            check("t4_no_gnt", job.gnt, 0);
        end
        job.res_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_after_hs", {job.res_valid, job.gnt}, 0);
        @(posedge clk); #1;
        check("t4_gnt_next", job.gnt, 4'b0010);
        job.req[1] = 1'b0;
        wait_idle();

        // A request dropped while busy is never granted
        gnt1_seen = 0;
        set_ops(0, mk_op(32'h00310000, 32'h00320000, 32'h00033000, 32'h00003400, 32'h00000035, 1'b0));
        job.req[0] = 1'b1;
        wait_gnt(0, got);
        job.req[0] = 1'b0;
        check("t6_gnt_seen", got, 1);
        @(posedge clk); #1;
        job.req[1] = 1'b1;
        @(posedge clk); #1;
        job.req[1] = 1'b0;
        wait_idle();
        repeat (6) @(posedge clk);
        #1;
        check("t6_never_granted", gnt1_seen, 0);
        check("t6_idle", {busy, job.res_valid}, 0);

        // Asynchronous reset in the middle of RUN drops the job
        set_ops(0, mk_op(32'h00410000, 32'h00420000, 32'h00043000, 32'h00004400, 32'h00000045, 1'b1));
        job.req[0] = 1'b1;
        wait_gnt(0, got);
        job.req[0] = 1'b0;
        check("t5_gnt_seen", got, 1);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t5_reset_outputs", {job.gnt, job.res_valid, job.res_err, job.res_data, job.res_id, busy,
                                   core_spot, core_strike, core_timetm, core_sigma, core_rate, core_otype}, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_job(2, mk_op(32'h00510000, 32'h00520000, 32'h00053000, 32'h00005400, 32'h00000055, 1'b0), lat);
        check("t5_latency", lat, CORE_LAT);
        check("t5_res", {job.res_err, job.res_id}, {1'b0, 2'd2});
        wait_idle();

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
